pipe_hazard_ctrl: RTL and testbench

Central stall/flush controller for the five-stage RISC-V pipeline. It drives the write enables and bubble-insert flushes of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipe registers. It resolves three conditions:
- load-use hazards;
- taken branches resolved in MEM;
- multi-cycle data-memory accesses, via a req/ready handshake with a timeout watchdog.

It also keeps stall and flush performance counters.

---
 rtl/pipe_hazard_ctrl.sv | 168 ++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller for the five-stage pipeline.
// Resolves load-use hazards, taken branches in MEM and multi-cycle data-memory
// accesses (req/ready handshake with timeout watchdog), and keeps stall/flush
// performance counters.
module pipe_hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead_EX,
    input  logic [4:0]  RD_EX,
    input  logic [4:0]  RS1_ID,
    input  logic [4:0]  RS2_ID,
    input  logic        Branch_MEM,
    input  logic        ZERO_MEM,
    input  logic        MemRead_MEM,
    input  logic        MemWrite_MEM,
    input  logic        dmem_ready,
    output logic        PC_write,
    output logic        IF_ID_write,
    output logic        ID_EX_write,
    output logic        EX_MEM_write,
    output logic        MEM_WB_write,
    output logic        IF_ID_flush,
    output logic        ID_EX_flush,
    output logic        EX_MEM_flush,
    output logic        MEM_WB_flush,
    output logic        pc_sel,
    output logic        dmem_req,
    output logic        mem_err,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
);

    localparam logic [7:0] TIMEOUT_W = 8'(MEM_TIMEOUT);

    typedef enum logic [1:0] {
        RUN,
        MEM_WAIT,
        ERROR
    } state_t;

    state_t      state;
    logic [7:0]  wait_cnt;
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;
    logic        mem_err_q;

    logic        active;
    logic        mreq;
    logic        mem_stall;
    logic        br_taken;
    logic        load_use;

    // Hazard condition decode from the current state and stage inputs
    always_comb begin
        active    = (state != ERROR);
        mreq      = MemRead_MEM | MemWrite_MEM;
        mem_stall = active & mreq & ~dmem_ready;
        br_taken  = Branch_MEM & ZERO_MEM;
        load_use  = MemRead_EX & (RD_EX != '0) &
                    ((RD_EX == RS1_ID) | (RD_EX == RS2_ID));
    end

    // Zero-latency pipe controls, resolved in priority order
    always_comb begin
        PC_write     = 1'b0;
        IF_ID_write  = 1'b0;
        ID_EX_write  = 1'b0;
        EX_MEM_write = 1'b0;
        MEM_WB_write = 1'b0;
        IF_ID_flush  = 1'b0;
        ID_EX_flush  = 1'b0;
        EX_MEM_flush = 1'b0;
        MEM_WB_flush = 1'b0;
        pc_sel       = 1'b0;
        dmem_req     = 1'b0;
        if (!reset && active) begin
            dmem_req = mreq;
            if (mem_stall) begin
                // Freeze the front of the pipe; the memory stage drains a bubble
                MEM_WB_write = 1'b1;
                MEM_WB_flush = 1'b1;
            end else if (br_taken) begin
                PC_write     = 1'b1;
                IF_ID_write  = 1'b1;
                ID_EX_write  = 1'b1;
                EX_MEM_write = 1'b1;
                MEM_WB_write = 1'b1;
                IF_ID_flush  = 1'b1;
                ID_EX_flush  = 1'b1;
                EX_MEM_flush = 1'b1;
                pc_sel       = 1'b1;
            end else if (load_use) begin
                ID_EX_write  = 1'b1;
                EX_MEM_write = 1'b1;
                MEM_WB_write = 1'b1;
                ID_EX_flush  = 1'b1;
            end else begin
                PC_write     = 1'b1;
                IF_ID_write  = 1'b1;
                ID_EX_write  = 1'b1;
                EX_MEM_write = 1'b1;
                MEM_WB_write = 1'b1;
            end
        end
    end

    // State machine, memory-wait watchdog and performance counters
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= RUN;
            wait_cnt    <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            mem_err_q   <= 1'b0;
        end else begin
            if (active) begin
                if (mem_stall)
                    stall_cnt_q <= stall_cnt_q + 32'd1;
                else if (br_taken)
                    flush_cnt_q <= flush_cnt_q + 32'd1;
                else if (load_use)
                    stall_cnt_q <= stall_cnt_q + 32'd1;
            end

            case (state)
                RUN: begin
                    if (mem_stall) begin
                        // wait_cnt counts not-ready cycles including the current one
                        if (TIMEOUT_W == 8'd1) begin
                            state     <= ERROR;
                            mem_err_q <= 1'b1;
                        end else begin
                            state    <= MEM_WAIT;
                            wait_cnt <= 8'd1;
                        end
                    end
                end
                MEM_WAIT: begin
                    if (mem_stall) begin
                        if (wait_cnt + 8'd1 == TIMEOUT_W) begin
                            state     <= ERROR;
                            mem_err_q <= 1'b1;
                        end else begin
                            wait_cnt <= wait_cnt + 8'd1;
                        end
                    end else begin
                        state    <= RUN;
                        wait_cnt <= '0;
                    end
                end
                ERROR: begin
                    state <= ERROR;
                end
                default: begin
                    state    <= RUN;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

    assign mem_err   = mem_err_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (MEM_TIMEOUT = 4).
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemRead_EX;
    logic [4:0]  RD_EX, RS1_ID, RS2_ID;
    logic        Branch_MEM, ZERO_MEM;
    logic        MemRead_MEM, MemWrite_MEM;
    logic        dmem_ready;
    logic        PC_write, IF_ID_write, ID_EX_write, EX_MEM_write, MEM_WB_write;
    logic        IF_ID_flush, ID_EX_flush, EX_MEM_flush, MEM_WB_flush;
    logic        pc_sel, dmem_req, mem_err;
    logic [31:0] stall_cnt, flush_cnt;
    logic [11:0] ctrl;

    int unsigned checks = 0;
    int unsigned errors = 0;

    // {writes PC,IF_ID,ID_EX,EX_MEM,MEM_WB, flushes IF_ID,ID_EX,EX_MEM,MEM_WB, pc_sel, dmem_req, mem_err}
    localparam logic [11:0] C_OFF     = 12'b00000_0000_0_0_0;
    localparam logic [11:0] C_RUN     = 12'b11111_0000_0_0_0;
    localparam logic [11:0] C_RUN_REQ = 12'b11111_0000_0_1_0;
    localparam logic [11:0] C_LU      = 12'b00111_0100_0_0_0;
    localparam logic [11:0] C_BR      = 12'b11111_1110_1_0_0;
    localparam logic [11:0] C_MST     = 12'b00001_0001_0_1_0;
    localparam logic [11:0] C_ERR     = 12'b00000_0000_0_0_1;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .MemRead_EX   (MemRead_EX),
        .RD_EX        (RD_EX),
        .RS1_ID       (RS1_ID),
        .RS2_ID       (RS2_ID),
        .Branch_MEM   (Branch_MEM),
        .ZERO_MEM     (ZERO_MEM),
        .MemRead_MEM  (MemRead_MEM),
        .MemWrite_MEM (MemWrite_MEM),
        .dmem_ready   (dmem_ready),
        .PC_write     (PC_write),
        .IF_ID_write  (IF_ID_write),
        .ID_EX_write  (ID_EX_write),
        .EX_MEM_write (EX_MEM_write),
        .MEM_WB_write (MEM_WB_write),
        .IF_ID_flush  (IF_ID_flush),
        .ID_EX_flush  (ID_EX_flush),
        .EX_MEM_flush (EX_MEM_flush),
        .MEM_WB_flush (MEM_WB_flush),
        .pc_sel       (pc_sel),
        .dmem_req     (dmem_req),
        .mem_err      (mem_err),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    assign ctrl = {PC_write, IF_ID_write, ID_EX_write, EX_MEM_write, MEM_WB_write,
                   IF_ID_flush, ID_EX_flush, EX_MEM_flush, MEM_WB_flush,
                   pc_sel, dmem_req, mem_err};

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        MemRead_EX   = 1'b0;
        RD_EX        = '0;
        RS1_ID       = '0;
        RS2_ID       = '0;
        Branch_MEM   = 1'b0;
        ZERO_MEM     = 1'b0;
        MemRead_MEM  = 1'b0;
        MemWrite_MEM = 1'b0;
        dmem_ready   = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        cyc();
        cyc();
        #1 check("reset_ctrl", 32'(ctrl), 32'(C_OFF));
        check("reset_stall", stall_cnt, 32'd0);
        check("reset_flush", flush_cnt, 32'd0);
        reset = 1'b0;
        #1 check("run_idle", 32'(ctrl), 32'(C_RUN));

        // Load-use on RS2: one-cycle stall
        cyc();
        MemRead_EX = 1'b1; RD_EX = 5'd5; RS1_ID = 5'd3; RS2_ID = 5'd5;
        #1 check("lu_ctrl", 32'(ctrl), 32'(C_LU));
        cyc();
        check("lu_stall_cnt", stall_cnt, 32'd1);
        idle();
        #1 check("lu_clear", 32'(ctrl), 32'(C_RUN));

        // Load into x0 never stalls
        cyc();
        MemRead_EX = 1'b1; RD_EX = 5'd0; RS1_ID = 5'd0; RS2_ID = 5'd0;
        #1 check("lu_x0_ctrl", 32'(ctrl), 32'(C_RUN));
        cyc();
        check("lu_x0_stall_cnt", stall_cnt, 32'd1);

        // Taken branch overrides a simultaneous load-use
        MemRead_EX = 1'b1; RD_EX = 5'd7; RS1_ID = 5'd7; RS2_ID = 5'd1;
        Branch_MEM = 1'b1; ZERO_MEM = 1'b1;
        #1 check("br_ctrl", 32'(ctrl), 32'(C_BR));
        cyc();
        check("br_flush_cnt", flush_cnt, 32'd1);
        check("br_stall_cnt", stall_cnt, 32'd1);
        idle();

        // Memory wait: 3 not-ready cycles then ready; branch/load-use ignored while stalled
        MemRead_MEM = 1'b1; dmem_ready = 1'b0;
        Branch_MEM = 1'b1; ZERO_MEM = 1'b1;
        MemRead_EX = 1'b1; RD_EX = 5'd9; RS1_ID = 5'd9;
        #1 check("mw_stall0", 32'(ctrl), 32'(C_MST));
        cyc();
        Branch_MEM = 1'b0; ZERO_MEM = 1'b0; MemRead_EX = 1'b0;
        #1 check("mw_stall1", 32'(ctrl), 32'(C_MST));
        cyc();
        check("mw_stall2", 32'(ctrl), 32'(C_MST));
        cyc();
        dmem_ready = 1'b1;
        #1 check("mw_ready", 32'(ctrl), 32'(C_RUN_REQ));
        cyc();
        check("mw_stall_cnt", stall_cnt, 32'd4);
        check("mw_flush_cnt", flush_cnt, 32'd1);
        idle();
        #1 check("mw_back_run", 32'(ctrl), 32'(C_RUN));

        // Timeout: 4 not-ready cycles, then sticky error
        cyc();
        MemWrite_MEM = 1'b1; dmem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1 check($sformatf("to_stall%0d", i), 32'(ctrl), 32'(C_MST));
            cyc();
        end
        check("to_err_entry", 32'(ctrl), 32'(C_ERR));
        check("to_stall_cnt", stall_cnt, 32'd8);
        for (int i = 0; i < 10; i++) begin
            Branch_MEM = i[0]; ZERO_MEM = 1'b1;
            MemRead_EX = 1'b1; RD_EX = 5'd4; RS1_ID = 5'd4;
            dmem_ready = (i == 5);
            #1 check($sformatf("to_hold%0d", i), 32'(ctrl), 32'(C_ERR));
            cyc();
        end
        check("to_hold_stall", stall_cnt, 32'd8);
        check("to_hold_flush", flush_cnt, 32'd1);

        // Reset out of ERROR
        idle();
        reset = 1'b1;
        #1 check("err_rst_ctrl", 32'(ctrl), 32'(C_ERR));
        cyc();
        reset = 1'b0;
        #1 check("err_rst_run", 32'(ctrl), 32'(C_RUN));
        check("err_rst_stall", stall_cnt, 32'd0);
        check("err_rst_flush", flush_cnt, 32'd0);

        // Reset mid-wait
        cyc();
        MemRead_MEM = 1'b1; dmem_ready = 1'b0;
        #1 check("mid_stall0", 32'(ctrl), 32'(C_MST));
        cyc();
        check("mid_stall1", 32'(ctrl), 32'(C_MST));
        reset = 1'b1;
        #1 check("mid_rst_ctrl", 32'(ctrl), 32'(C_OFF));
        cyc();
        reset = 1'b0;
        idle();
        #1 check("mid_rst_run", 32'(ctrl), 32'(C_RUN));
        check("mid_rst_stall", stall_cnt, 32'd0);
        // Fresh watchdog: three not-ready cycles must not reach ERROR
        cyc();
        MemRead_MEM = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 check($sformatf("mid_rewait%0d", i), 32'(ctrl), 32'(C_MST));
            cyc();
        end
        dmem_ready = 1'b1;
        #1 check("mid_rewait_ready", 32'(ctrl), 32'(C_RUN_REQ));
        cyc();
        idle();
        check("mid_rewait_cnt", stall_cnt, 32'd3);

        // Stall counter wrap via backdoor preload
        force dut.stall_cnt_q = 32'hFFFF_FFFF;
        #1 release dut.stall_cnt_q;
        #1 check("wrap_preload", stall_cnt, 32'hFFFF_FFFF);
        MemRead_EX = 1'b1; RD_EX = 5'd12; RS2_ID = 5'd12;
        #1 check("wrap_lu_ctrl", 32'(ctrl), 32'(C_LU));
        cyc();
        check("wrap_stall_cnt", stall_cnt, 32'd0);
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "bench time limit");
    end

endmodule
